calc_exec_ctrl: RTL
===================

CALC_EXEC_CTRL -- requirements
Module: calc_exec_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk_db and rst.
REQ-002 Port clk_db, input, 1 bit: block clock, all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port start, input, 1 bit: request to begin an operation.
REQ-005 Port abort, input, 1 bit: cancel the operation in progress.
REQ-006 Port op, input, 2 bits: operation code, 0=add, 1=sub, 2=mul, 3=div.
REQ-007 Port a_mag, input, 24 bits: operand A magnitude (unsigned integer); a_neg, input, 1 bit: sign of A.
REQ-008 Port b_mag, input, 24 bits: operand B magnitude (unsigned integer); b_neg, input, 1 bit: sign of B.
REQ-009 Port busy, output, 1 bit: operation in progress.
REQ-010 Port done, output, 1 bit: one-cycle completion pulse.
REQ-011 Port res_bcd, output, 28 bits: 7 packed BCD digits, digit 0 in bits [3:0].
REQ-012 Port res_neg, output, 1 bit: result sign.
REQ-013 Port err_ovf, output, 1 bit: overflow or out-of-range operand.
REQ-014 Port err_div0, output, 1 bit: division by zero.

Function
REQ-015 The FSM SHALL have the states IDLE, ALU, CHECK, CONV and DONE.
REQ-016 In IDLE, start=1 with abort=0 SHALL latch op, a_mag, a_neg, b_mag and b_neg, and the FSM SHALL enter ALU on the next cycle; busy SHALL be high in every non-IDLE state.
REQ-017 start SHALL be ignored when the FSM is not in IDLE, and input changes after acceptance SHALL have no effect.
REQ-018 Add/sub SHALL use sign-magnitude arithmetic and SHALL spend 1 cycle in ALU; effective subtraction SHALL yield the larger magnitude minus the smaller, with the sign taken from the larger operand.
REQ-019 Mul SHALL be a 24-iteration shift-add with a 48-bit product and SHALL spend 24 cycles in ALU; result sign SHALL be a_neg XOR b_neg.
REQ-020 Div SHALL be a 24-iteration restoring divide and SHALL spend 24 cycles in ALU; the quotient SHALL be truncated toward zero, the remainder discarded, and the sign SHALL be a_neg XOR b_neg.
REQ-021 CHECK SHALL last 1 cycle and apply checks in priority order: div with b_mag=0 sets err_div0; otherwise a_mag or b_mag greater than 9,999,999, or a result magnitude greater than 9,999,999, sets err_ovf.
REQ-022 On any error, CHECK SHALL go directly to DONE with res_bcd=0 and res_neg=0; otherwise it SHALL enter CONV.
REQ-023 CONV SHALL perform a 24-cycle double-dabble binary-to-BCD conversion.
REQ-024 A zero magnitude result SHALL force res_neg=0 (no negative zero).
REQ-025 DONE SHALL last 1 cycle: res_bcd, res_neg and both error flags are updated, done=1, and the FSM returns to IDLE.
REQ-026 res_bcd, res_neg, err_ovf and err_div0 SHALL be updated only in DONE and SHALL hold their values until the next DONE.
REQ-027 Latency, counted from the accepting edge, SHALL be: done at cycle 27 for add/sub and cycle 50 for mul/div; with an error, done at cycle 3 for add/sub and cycle 26 for mul/div.
REQ-028 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge without a done pulse and without changing any result output.
REQ-029 If abort and start are both high in IDLE, abort SHALL win and start SHALL be ignored.

Reset
REQ-030 When rst=1, the FSM SHALL go to IDLE and busy, done, res_bcd, res_neg, err_ovf and err_div0 SHALL all be 0.
REQ-031 Reset SHALL take priority over start and abort, including in the middle of an operation.

Structure
REQ-032 Package calc_pkg SHALL hold the op codes, the FSM state encoding, MAG_W=24, NDIG=7 and MAX_MAG=9,999,999.
REQ-033 The conversion SHALL be a sub-module named calc_bin2bcd, an iterative double-dabble with start/done handshake, taking a 24-bit input and producing a 28-bit output in 24 cycles.

Verification
REQ-034 Add: op=0, A=123, B=456 -> res_bcd=0x0000579, res_neg=0, done at cycle 27.
REQ-035 Sub: op=1, A=25, B=100 -> res_bcd=0x0000075, res_neg=1. Add of mixed signs: op=0, A=-40, B=+40 -> res_bcd=0, res_neg=0.
REQ-036 Mul: op=2, A=1234, B=5678 -> res_bcd=0x7006652, done at cycle 50. Overflow: op=2, A=5000, B=2000 -> err_ovf=1, res_bcd=0, done at cycle 26.
REQ-037 Div: op=3, A=-100, B=7 -> res_bcd=0x0000014, res_neg=1. Divide by zero: op=3, A=5, B=0 -> err_div0=1, err_ovf=0, res_bcd=0.
REQ-038 Abort: abort at cycle 10 of a mul -> busy=0 next cycle, no done, prior result outputs unchanged; start during busy is ignored.
REQ-039 Reset: rst mid-CONV -> all outputs 0 next cycle; the next start completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the sign-magnitude BCD calculator.
package calc_pkg;

  localparam int MAG_W = 24;
  localparam int NDIG  = 7;
  localparam int BCD_W = 4 * NDIG;
  localparam logic [MAG_W-1:0] MAX_MAG = 24'd9_999_999;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALU   = 3'd1,
    ST_CHECK = 3'd2,
    ST_CONV  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/calc_bin2bcd.sv
// Iterative double-dabble: 24-bit binary to 7 BCD digits, one shift per cycle.
// The start cycle already performs the first shift so the result lands 24 edges after start.
module calc_bin2bcd
  import calc_pkg::*;
(
  input  logic             clk_db,
  input  logic             rst,
  input  logic             start,
  input  logic [MAG_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [BCD_W-1:0]       bcd_reg;
  logic [MAG_W-1:0]       bin_reg;
  logic [4:0]             cnt_reg;
  logic                   run_reg;
  logic                   done_reg;
  logic [BCD_W-1:0]       bcd_src;
  logic [MAG_W-1:0]       bin_src;
  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+MAG_W-1:0] step_val;

  assign bcd_src = start ? '0 : bcd_reg;
  assign bin_src = start ? bin : bin_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_src[4*gi +: 4] >= 4'd5) ?
                                  bcd_src[4*gi +: 4] + 4'd3 : bcd_src[4*gi +: 4];
    end
  endgenerate

  assign step_val = {bcd_adj, bin_src} << 1;

  always_ff @(posedge clk_db) begin
    if (rst) begin
      bcd_reg  <= '0;
      bin_reg  <= '0;
      cnt_reg  <= '0;
      run_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start || run_reg) begin
        {bcd_reg, bin_reg} <= step_val;
      end
      if (start) begin
        cnt_reg <= 5'd1;
        run_reg <= 1'b1;
      end else if (run_reg) begin
        cnt_reg <= cnt_reg + 5'd1;
        if (cnt_reg == 5'd23) begin
          run_reg  <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done = done_reg;
  assign bcd  = bcd_reg;

endmodule

// File: rtl/calc_exec_ctrl.sv
// Calculator execution controller: sign-magnitude add/sub, iterative mul/div,
// range checking and BCD conversion, with abort and registered result outputs.
module calc_exec_ctrl
  import calc_pkg::*;
(
  input  logic             clk_db,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       op,
  input  logic [MAG_W-1:0] a_mag,
  input  logic             a_neg,
  input  logic [MAG_W-1:0] b_mag,
  input  logic             b_neg,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] res_bcd,
  output logic             res_neg,
  output logic             err_ovf,
  output logic             err_div0
);

  state_t             state_reg, state_next;
  logic [1:0]         op_reg;
  logic [MAG_W-1:0]   a_reg, b_reg, wb_reg;
  logic               a_neg_reg, b_neg_reg, sign_reg;
  logic [2*MAG_W-1:0] wa_reg, acc_reg;
  logic [4:0]         cnt_reg;
  logic [BCD_W-1:0]   res_bcd_reg;
  logic               res_neg_reg, err_ovf_reg, err_div0_reg;

  logic               b_eff_neg, eff_sub, addsub_neg;
  logic [MAG_W:0]     addsub_mag;
  logic [MAG_W:0]     rem_sh;
  logic               div_ge;
  logic [2*MAG_W-1:0] res_mag;
  logic               chk_div0, chk_ovf;
  logic               conv_start, conv_done, conv_clear;
  logic [BCD_W-1:0]   conv_bcd;

  // Sign-magnitude add/sub: effective subtraction keeps the larger magnitude's sign.
  always_comb begin
    b_eff_neg  = b_neg_reg ^ (op_reg == OP_SUB);
    eff_sub    = a_neg_reg ^ b_eff_neg;
    addsub_neg = a_neg_reg;
    addsub_mag = {1'b0, a_reg} + {1'b0, b_reg};
    if (eff_sub) begin
      if (a_reg >= b_reg) begin
        addsub_mag = {1'b0, a_reg} - {1'b0, b_reg};
      end else begin
        addsub_mag = {1'b0, b_reg} - {1'b0, a_reg};
        addsub_neg = b_eff_neg;
      end
    end
  end

  // Restoring divide: dividend shifts out of wb_reg while quotient bits shift in.
  assign rem_sh  = {acc_reg[MAG_W-1:0], wb_reg[MAG_W-1]};
  assign div_ge  = rem_sh >= {1'b0, b_reg};
  assign res_mag = (op_reg == OP_DIV) ? {{MAG_W{1'b0}}, wb_reg} : acc_reg;

  assign chk_div0 = (op_reg == OP_DIV) && (b_reg == '0);
  assign chk_ovf  = (a_reg > MAX_MAG) || (b_reg > MAX_MAG) ||
                    (res_mag > {{MAG_W{1'b0}}, MAX_MAG});

  always_comb begin
    state_next = state_reg;
    conv_start = 1'b0;
    case (state_reg)
      ST_IDLE:  if (start && !abort) state_next = ST_ALU;
      ST_ALU:   if (!op_reg[1] || cnt_reg == 5'd23) state_next = ST_CHECK;
      ST_CHECK: begin
        if (chk_div0 || chk_ovf) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_CONV;
          conv_start = 1'b1;
        end
      end
      ST_CONV:  if (conv_done) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort && state_reg != ST_IDLE) begin
      state_next = ST_IDLE;
      conv_start = 1'b0;
    end
  end

  assign conv_clear = rst || abort;

  calc_bin2bcd u_bin2bcd (
    .clk_db (clk_db),
    .rst    (conv_clear),
    .start  (conv_start),
    .bin    (res_mag[MAG_W-1:0]),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  always_ff @(posedge clk_db) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      op_reg       <= OP_ADD;
      a_reg        <= '0;
      b_reg        <= '0;
      a_neg_reg    <= 1'b0;
      b_neg_reg    <= 1'b0;
      sign_reg     <= 1'b0;
      wa_reg       <= '0;
      wb_reg       <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      res_bcd_reg  <= '0;
      res_neg_reg  <= 1'b0;
      err_ovf_reg  <= 1'b0;
      err_div0_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: if (start && !abort) begin
          op_reg    <= op;
          a_reg     <= a_mag;
          b_reg     <= b_mag;
          a_neg_reg <= a_neg;
          b_neg_reg <= b_neg;
          sign_reg  <= a_neg ^ b_neg;
          wa_reg    <= {{MAG_W{1'b0}}, a_mag};
          wb_reg    <= (op == OP_DIV) ? a_mag : b_mag;
          acc_reg   <= '0;
          cnt_reg   <= '0;
        end
        ST_ALU: begin
          cnt_reg <= cnt_reg + 5'd1;
          case (op_reg)
            OP_MUL: begin
              if (wb_reg[0]) acc_reg <= acc_reg + wa_reg;
              wa_reg <= wa_reg << 1;
              wb_reg <= wb_reg >> 1;
            end
            OP_DIV: begin
              acc_reg <= {{(MAG_W-1){1'b0}}, div_ge ? rem_sh - {1'b0, b_reg} : rem_sh};
              wb_reg  <= {wb_reg[MAG_W-2:0], div_ge};
            end
            default: begin
              acc_reg  <= {{(MAG_W-1){1'b0}}, addsub_mag};
              sign_reg <= addsub_neg;
            end
          endcase
        end
        ST_CHECK: sign_reg <= sign_reg && (res_mag != '0);
        default: ;
      endcase

      // Results only change on the edge that enters DONE; CHECK->DONE means an error.
      if (state_next == ST_DONE) begin
        if (state_reg == ST_CHECK) begin
          res_bcd_reg  <= '0;
          res_neg_reg  <= 1'b0;
          err_div0_reg <= chk_div0;
          err_ovf_reg  <= !chk_div0 && chk_ovf;
        end else begin
          res_bcd_reg  <= conv_bcd;
          res_neg_reg  <= sign_reg;
          err_div0_reg <= 1'b0;
          err_ovf_reg  <= 1'b0;
        end
      end
    end
  end

  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_DONE);
  assign res_bcd  = res_bcd_reg;
  assign res_neg  = res_neg_reg;
  assign err_ovf  = err_ovf_reg;
  assign err_div0 = err_div0_reg;

endmodule
